// File: rtl/filtro_entrada.sv
// Input conditioning: per-bit two-flop synchronizer followed by a stability
// counter, producing a registered debounced bus and a one-cycle change strobe.
module filtro_entrada #(
  parameter int LARGURA        = 2,
  parameter int ESTAVEL_CICLOS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LARGURA-1:0] bruto,
  output logic [LARGURA-1:0] entrada_limpa,
  output logic               mudou
);

  localparam int CW = (ESTAVEL_CICLOS > 1) ? $clog2(ESTAVEL_CICLOS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ESTAVEL_CICLOS - 1);

  logic [LARGURA-1:0] r_s1;
  logic [LARGURA-1:0] r_s2;
  logic [LARGURA-1:0] r_limpa;
  logic               r_mudou;
  logic [CW-1:0]      r_cnt     [LARGURA];
  logic [CW-1:0]      w_cnt_nxt [LARGURA];
  logic [LARGURA-1:0] w_flip;

  // Agreement with the clean value wins over reaching the threshold, so a
  // bit returning on the final counting edge never flips.
  always_comb begin
    w_flip = '0;
    for (int i = 0; i < LARGURA; i++) begin
      w_cnt_nxt[i] = '0;
      if (r_s2[i] != r_limpa[i]) begin
        if (r_cnt[i] == LAST) begin
          w_flip[i] = 1'b1;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_limpa <= '0;
      r_mudou <= 1'b0;
      for (int i = 0; i < LARGURA; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1    <= bruto;
      r_s2    <= r_s1;
      r_limpa <= r_limpa ^ w_flip;
      r_mudou <= |w_flip;
      for (int i = 0; i < LARGURA; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign entrada_limpa = r_limpa;
  assign mudou         = r_mudou;

endmodule

// File: doc/filtro_entrada.md
# filtro_entrada

Input conditioning stage that sits directly upstream of the edge detector. It takes raw, asynchronous, possibly bouncing 2-bit inputs from switches or buttons and passes each bit through a two-flop synchronizer and a per-bit stability counter. It presents a clean, registered, glitch-free `entrada_limpa` bus that connects straight to the detector's `entrada` input. A one-cycle `mudou` strobe marks every cycle in which the clean bus changes.

## Interface
- `LARGURA`, default 2: number of independent input bits. Must be ≥ 1.
- `ESTAVEL_CICLOS`, default 4: number of consecutive synchronized cycles a bit must disagree with its clean value before the clean value flips. Must be ≥ 1.

- `clk`  in  1  single clock. All state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset. The block is held in reset while `rst` = 0.
- `bruto`  in  `LARGURA`  raw asynchronous inputs.
- `entrada_limpa`  out  `LARGURA`  debounced, synchronized value. Registered.
- `mudou`  out  1  high for exactly one cycle when any bit of `entrada_limpa` changes. Registered.

## Operation
- **Synchronizer**, per bit: `s1 <= bruto[i]`, then `s2 <= s1`. Only `s2` is used downstream. No logic sits between `s1` and `s2`.
- **Per-bit counter** `cnt[i]`:
  - Width is `max(1, clog2(ESTAVEL_CICLOS))`.
  - It is the only per-bit state besides `s1`, `s2` and the output bit. There is no separate FSM; each bit has an implicit two-state behaviour, STABLE (`cnt` = 0) and COUNTING (`cnt` > 0).
- **Update rule**, per bit, each rising edge:
  - If `s2 == entrada_limpa[i]`: `cnt <= 0`. Any partial count is discarded, so a glitch shorter than `ESTAVEL_CICLOS` cycles never propagates.
  - Else if `cnt == ESTAVEL_CICLOS-1`: `entrada_limpa[i] <= s2`, `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
- **Bit independence:** bits are fully independent. Counters never interact, and a bounce on one bit has no effect on another bit's count.
- **`mudou`:** registered OR of all per-bit "flip this edge" conditions.
  - It goes high on the same edge that `entrada_limpa` changes, and stays high for one cycle.
  - Several bits flipping on the same edge produce a single one-cycle pulse.
  - Bits flipping on consecutive edges produce `mudou` high on both cycles.
- **`ESTAVEL_CICLOS` = 1:** the counter width is 1 but the counter stays at 0. A disagreement flips the output on the first edge at which `s2` differs.
- **Arithmetic:** the counter never exceeds `ESTAVEL_CICLOS-1`, so wrap-around is impossible by construction.

## Timing
- **Reset values:** while `rst` = 0, asynchronously force `s1`, `s2`, `cnt`, `entrada_limpa` and `mudou` to 0.
- **Reset mid-count:** all progress is lost. After release, a bit whose `bruto` is 1 needs the full latency below to reach 1.
- **First sampling edge after release:** normal operation; no extra idle cycles.
- **Latency:** `bruto[i]` changes and then stays constant. Call E1 the first rising edge that samples the new value into `s1`. Then:
  - `s2` takes the new value at E2.
  - `cnt` reaches 1 at E3.
  - `entrada_limpa[i]` and `mudou` update at edge E(`ESTAVEL_CICLOS`+2).
  - With the default of 4, that is E6.
- **Rejection threshold:** a disagreement lasting `ESTAVEL_CICLOS`-1 or fewer `s2` cycles is rejected. Exactly `ESTAVEL_CICLOS` cycles is accepted.
- **Return during counting:** if `s2` returns to the clean value on the edge where `cnt` would have hit the threshold, the rule compares first. `cnt` clears and there is no flip.
- **Throughput:** `entrada_limpa[i]` can flip at most once per `ESTAVEL_CICLOS` cycles.

## Test plan
All scenarios use `LARGURA` = 2 and `ESTAVEL_CICLOS` = 4.

1. **Reset.** Stimulus: `rst` = 0 with `bruto` = 2'b11, asserted asynchronously between clock edges, then released. Required: `entrada_limpa` = 2'b00 and `mudou` = 0 immediately during reset. After release, `entrada_limpa` = 2'b11 on the 6th rising edge, with `mudou` = 1 for that single cycle.
2. **Clean step.** Stimulus: from 2'b00, set `bruto` = 2'b01 before edge E1. Required: `entrada_limpa` stays 2'b00 through E5, becomes 2'b01 at E6, and `mudou` pulses exactly once at E6.
3. **Glitch rejection.** Stimulus: from 2'b00, set `bruto[1]` to 1 for 3 cycles, then back to 0. Required: `entrada_limpa` stays 2'b00 and `mudou` never asserts. Repeat with a 4-cycle pulse: required `entrada_limpa[1]` goes 1, then returns to 0 four cycles later, with two separate `mudou` pulses.
4. **Bounce.** Stimulus: `bruto[0]` pattern 1,0,1,1,0,1,1,1,1, then held at 1. Required: exactly one transition of `entrada_limpa[0]` to 1, on the 6th edge after the start of the final run of 1s, and one `mudou` pulse.
5. **Simultaneous bits.** Stimulus: `bruto` changes 2'b00→2'b11 on a single edge. Required: both bits flip on the same edge, and `mudou` is high for one cycle, not two.
6. **Reset mid-count.** Stimulus: `bruto` = 2'b10 held for 4 edges, then pulse `rst` = 0 for one cycle, then release. Required: `entrada_limpa` = 2'b00 during and after reset until 6 edges post-release, then 2'b10.
